hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Parametrised hazard and forwarding controller for the pipelined RV32 core.
- Sits beside the fetch/decode/execute/memory stage blocks and drives their stall, flush and forwarding controls.
- Generalises the fixed single-stall scheme in four ways:
  - configurable count of source operands;
  - configurable data-memory latency, handled by a wait FSM;
  - load-use and branch hazard resolution;
  - saturating performance counters for stall and flush cycles.

Parameters:
- REG_AW, 5, register index width.
- NUM_SRC, 2, source operands per instruction (1..3).
- MEM_LATENCY, 1, data-memory access cycles (1..15); >1 enables the wait FSM.
- CNT_WIDTH, 16, width of each performance counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- trigger  in  1  external global stall.
- RsD  in  NUM_SRC*REG_AW  decode-stage source indices; operand i at [i*REG_AW +: REG_AW].
- RsE  in  NUM_SRC*REG_AW  execute-stage source indices, same packing.
- RdE  in  REG_AW  execute destination.
- LoadE  in  1  execute instruction is a load.
- PCSrcE  in  1  taken branch/jump resolved in execute.
- RdM  in  REG_AW  memory-stage destination.
- RegWriteM  in  1  memory-stage register write.
- MemReqM  in  1  memory stage issues a load/store.
- RdW  in  REG_AW  writeback destination.
- RegWriteW  in  1  writeback register write.
- StallF, StallD, StallE, StallM  out  1 each  hold the corresponding pipeline register.
- FlushD, FlushE, FlushW  out  1 each  insert a bubble.
- ForwardE  out  NUM_SRC*2  per-operand select: 00 register file, 01 ResultW, 10 ALUResultM.
- mem_busy  out  1  wait FSM in WAIT.
- stall_cnt  out  CNT_WIDTH  load-use plus memory-wait cycles.
- flush_cnt  out  CNT_WIDTH  branch-flush cycles.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM to IDLE; wait counter, stall_cnt and flush_cnt to 0.
  - While rst=0, all stall/flush outputs are 0, ForwardE is 0 and mem_busy is 0.
- Forwarding (combinational, per operand i):
  - 10 if RegWriteM & RdM!=0 & RdM==RsE[i].
  - Otherwise 01 if RegWriteW & RdW!=0 & RdW==RsE[i].
  - Otherwise 00.
  - Memory stage has priority over writeback.
  - Forwarding is independent of all stall states.
- Wait FSM (states IDLE, WAIT; only when MEM_LATENCY>1):
  - IDLE -> WAIT on MemReqM & !trigger; wait counter loads MEM_LATENCY-1.
  - In WAIT, counter decrements each cycle trigger=0 and freezes while trigger=1.
  - WAIT -> IDLE when counter==1 and it decrements; no extra cycle.
  - In WAIT: StallF/D/E/M=1, FlushW=1, mem_busy=1.
  - A memory op therefore occupies M for MEM_LATENCY cycles.
  - MEM_LATENCY=1: FSM stays in IDLE permanently.
- Hazard priority, highest first:
  1. WAIT state.
  2. trigger: all four stalls=1, no flushes, counters hold.
  3. PCSrcE: FlushD=1, FlushE=1, no stalls; suppresses any load-use hazard in the same cycle, since the instruction in D is wrong-path.
  4. Load-use: LoadE & RdE!=0 & RdE==any RsD[i] gives StallF=1, StallD=1, FlushE=1.
  5. Otherwise all outputs 0.
- Counters:
  - stall_cnt +1 on each cycle with an active load-use stall or WAIT with trigger=0.
  - flush_cnt +1 on each PCSrcE flush cycle.
  - Both saturate at all-ones and do not wrap.
  - Updates are registered; values are visible the next cycle.
- Reset asserted mid-WAIT: FSM returns to IDLE immediately and the pending access is abandoned.

Test Plan:
- RegWriteM=1, RdM=5, RegWriteW=1, RdW=5, RsE={5,5} -> ForwardE=1010. With RdM=0: 0101. With all indices 0: 0000.
- LoadE=1, RdE=7, RsD={3,7} -> StallF=StallD=FlushE=1 for one cycle. Same with RdE=0 -> no stall.
- LoadE=1, RdE=7, RsD op=7 and PCSrcE=1 in the same cycle -> FlushD=FlushE=1, StallF=StallD=0; flush_cnt increments by 1 and stall_cnt unchanged.
- MEM_LATENCY=3, single-cycle MemReqM pulse -> mem_busy and stalls high for 2 cycles, then IDLE; stall_cnt=2. Trigger held 3 cycles mid-WAIT -> total WAIT 5 cycles, stall_cnt still 2.
- MEM_LATENCY=3, assert rst=0 during the first WAIT cycle -> all outputs 0 asynchronously. After release, FSM is IDLE and counters are 0.
- CNT_WIDTH=4, 20 consecutive load-use cycles -> stall_cnt saturates at 15 and stays there.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for the pipelined RV32 core.
// Drives stall, flush and forwarding controls for the F/D/E/M/W stages.
// Ports:
//   clk, rst (async, active-low), trigger (external global stall)
//   RsD/RsE       packed decode/execute source indices, operand i at [i*REG_AW +: REG_AW]
//   RdE, LoadE    execute destination and load flag (load-use detection)
//   PCSrcE        taken branch/jump resolved in execute
//   RdM, RegWriteM, MemReqM  memory-stage destination, write enable, access request
//   RdW, RegWriteW           writeback destination and write enable
//   StallF/D/E/M, FlushD/E/W pipeline-register controls
//   ForwardE      per-operand select: 00 regfile, 01 ResultW, 10 ALUResultM
//   mem_busy      memory wait in progress
//   stall_cnt     saturating count of load-use and memory-wait cycles
//   flush_cnt     saturating count of branch-flush cycles
module hazard_ctrl #(
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned NUM_SRC     = 2,
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        trigger,
  input  logic [NUM_SRC*REG_AW-1:0]   RsD,
  input  logic [NUM_SRC*REG_AW-1:0]   RsE,
  input  logic [REG_AW-1:0]           RdE,
  input  logic                        LoadE,
  input  logic                        PCSrcE,
  input  logic [REG_AW-1:0]           RdM,
  input  logic                        RegWriteM,
  input  logic                        MemReqM,
  input  logic [REG_AW-1:0]           RdW,
  input  logic                        RegWriteW,
  output logic                        StallF,
  output logic                        StallD,
  output logic                        StallE,
  output logic                        StallM,
  output logic                        FlushD,
  output logic                        FlushE,
  output logic                        FlushW,
  output logic [NUM_SRC*2-1:0]        ForwardE,
  output logic                        mem_busy,
  output logic [CNT_WIDTH-1:0]        stall_cnt,
  output logic [CNT_WIDTH-1:0]        flush_cnt
);

  // Wait counter wide enough for the largest supported latency (15).
  localparam int unsigned WCW = 4;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [WCW-1:0]   wcnt, wcnt_nxt;
  logic             load_use;
  logic [NUM_SRC*2-1:0] fwd;
  logic [REG_AW-1:0] rs_e;
  logic             stall_inc;
  logic             flush_inc;

  // State register and wait counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  // Next state: a memory access holds the pipeline for MEM_LATENCY-1 extra
  // cycles; the external trigger freezes the countdown without ending it.
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    if (MEM_LATENCY > 1) begin
      case (state)
        S_IDLE: begin
          if (MemReqM && !trigger) begin
            state_nxt = S_WAIT;
            wcnt_nxt  = WCW'(MEM_LATENCY - 1);
          end
        end
        S_WAIT: begin
          if (!trigger) begin
            wcnt_nxt = wcnt - WCW'(1);
            if (wcnt == WCW'(1)) begin
              state_nxt = S_IDLE;
            end
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Load-use: execute-stage load targets a register decode wants to read.
  always_comb begin
    load_use = 1'b0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (RsD[i*REG_AW +: REG_AW] == RdE) begin
        load_use = 1'b1;
      end
    end
    load_use = load_use & LoadE & (RdE != '0);
  end

  // Forwarding select per operand; memory stage holds the newer value.
  always_comb begin
    fwd  = '0;
    rs_e = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      rs_e = RsE[i*REG_AW +: REG_AW];
      if (RegWriteM && (RdM != '0) && (RdM == rs_e)) begin
        fwd[i*2 +: 2] = 2'b10;
      end else if (RegWriteW && (RdW != '0) && (RdW == rs_e)) begin
        fwd[i*2 +: 2] = 2'b01;
      end
    end
  end

  assign ForwardE = rst ? fwd : '0;

  // Output decode in priority order: memory wait, trigger, branch, load-use.
  // A branch outranks load-use because the instruction in D is wrong-path.
  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    mem_busy  = 1'b0;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    if (!rst) begin
      // Everything quiet while reset is held.
    end else if (state == S_WAIT) begin
      StallF    = 1'b1;
      StallD    = 1'b1;
      StallE    = 1'b1;
      StallM    = 1'b1;
      FlushW    = 1'b1;
      mem_busy  = 1'b1;
      stall_inc = !trigger;
    end else if (trigger) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
    end else if (PCSrcE) begin
      FlushD    = 1'b1;
      FlushE    = 1'b1;
      flush_inc = 1'b1;
    end else if (load_use) begin
      StallF    = 1'b1;
      StallD    = 1'b1;
      FlushE    = 1'b1;
      stall_inc = 1'b1;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_WIDTH'(1);
      end
      if (flush_inc && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule
